// File: rtl/d5m_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// d5m_cfg_sequencer_if
//
// Bundles the two handshakes of the D5M configuration sequencer:
//   - runtime update request (upd_*): register writes requested after boot
//   - I2C write engine (wr_*): one 24-bit {reg, data} word per transaction
//
// Signals:
//   upd_valid  runtime write request
//   upd_addr   runtime register address
//   upd_data   runtime register data
//   upd_ready  runtime request accepted this cycle
//   wr_valid   word offered to the I2C engine
//   wr_dev     I2C device write address
//   wr_word    {reg[7:0], data[15:0]} to the engine
//   wr_ready   engine accepts the word
//   wr_done    one-cycle pulse, transaction finished
//   wr_nack    qualifies wr_done; an ACK slot was missed
//
// Modports:
//   master  the sequencer side
//   slave   the requester / engine side
// -----------------------------------------------------------------------------
interface d5m_cfg_sequencer_if;
    logic        upd_valid;
    logic [7:0]  upd_addr;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic        wr_valid;
    logic [7:0]  wr_dev;
    logic [23:0] wr_word;
    logic        wr_ready;
    logic        wr_done;
    logic        wr_nack;

    modport master (
        input  upd_valid, upd_addr, upd_data, wr_ready, wr_done, wr_nack,
        output upd_ready, wr_valid, wr_dev, wr_word
    );

    modport slave (
        output upd_valid, upd_addr, upd_data, wr_ready, wr_done, wr_nack,
        input  upd_ready, wr_valid, wr_dev, wr_word
    );
endinterface

// File: rtl/d5m_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// d5m_cfg_sequencer
//
// Walks the external D5M boot-register table and hands each {reg, data} word
// to the single I2C write engine, waiting for completion and retrying NACKed
// writes. After the table is done it forwards runtime register updates
// (exposure, gains) to the same engine.
//
// Build option:
//   D5M_CFG_RETRY_EN  defined   -> a NACKed word is re-issued up to MAX_RETRY
//                                  times before being abandoned.
//                     undefined -> any NACK abandons the word at once; no retry
//                                  counter exists and MAX_RETRY has no effect.
//
// Parameters:
//   NUM_REGS    boot-table entries (indices 0..NUM_REGS-1, max 32)
//   DEV_ADDR    I2C device write address driven on wr_dev
//   MAX_RETRY   retries per word after a NACK (1..7)
//   GAP_CYCLES  idle cycles after every completed write (>= 1)
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse, re-runs the boot table from index 0
//   tbl_index  boot-table entry being read
//   tbl_data   {reg, data} of entry tbl_index (combinational from the table)
//   bus        update request and I2C engine handshakes (master side)
//   busy       sequencer is neither idle nor finished
//   cfg_done   boot table finished, sticky until start or rst
//   cfg_err    sticky, a word was abandoned after its retries
// -----------------------------------------------------------------------------
module d5m_cfg_sequencer #(
    parameter int unsigned NUM_REGS   = 25,
    parameter logic [7:0]  DEV_ADDR   = 8'hBA,
    parameter int unsigned MAX_RETRY  = 3,
    parameter logic [15:0] GAP_CYCLES = 16'd500
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [4:0]                  tbl_index,
    input  logic [23:0]                 tbl_data,
    d5m_cfg_sequencer_if.master         bus,
    output logic                        busy,
    output logic                        cfg_done,
    output logic                        cfg_err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] WAIT      = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;
    localparam logic [2:0] UPD_ISSUE = 3'd6;
    localparam logic [2:0] UPD_WAIT  = 3'd7;

    localparam logic [4:0]  LAST_IDX = 5'(NUM_REGS - 1);
    localparam logic [15:0] GAP_LAST = GAP_CYCLES - 16'd1;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [15:0] gap_cnt;
    logic        in_upd;      // current word came from a runtime update
    logic        wr_valid_q;
    logic [23:0] wr_word_q;

    logic        wait_st;
    logic        nack_seen;
    logic        can_retry;
    logic        gap_end;
    logic        upd_accept;

    function automatic logic is_busy(input logic [2:0] s);
        return !(s == IDLE || s == DONE);
    endfunction

    function automatic logic is_issue(input logic [2:0] s);
        return (s == ISSUE || s == UPD_ISSUE);
    endfunction

    assign wait_st    = (state == WAIT) || (state == UPD_WAIT);
    assign nack_seen  = wait_st && bus.wr_done && bus.wr_nack;
    assign gap_end    = (state == GAP) && (gap_cnt == GAP_LAST);
    // start outranks a pending update, so ready is withheld whenever start is high
    assign upd_accept = (state == DONE) && !start && bus.upd_valid;

`ifdef D5M_CFG_RETRY_EN
    logic [2:0] retry_cnt;

    assign can_retry = (retry_cnt < 3'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= 3'd0;
        end else if (state == FETCH || upd_accept) begin
            retry_cnt <= 3'd0;
        end else if (nack_seen && can_retry) begin
            retry_cnt <= retry_cnt + 3'd1;
        end
    end
`else
    // MAX_RETRY has no effect in this build
    logic unused_max_retry;
    assign unused_max_retry = ^(3'(MAX_RETRY));
    assign can_retry        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: state_next = ISSUE;
            ISSUE: begin
                if (bus.wr_ready) state_next = WAIT;
            end
            UPD_ISSUE: begin
                if (bus.wr_ready) state_next = UPD_WAIT;
            end
            WAIT: begin
                if (bus.wr_done) begin
                    state_next = (bus.wr_nack && can_retry) ? ISSUE : GAP;
                end
            end
            UPD_WAIT: begin
                if (bus.wr_done) begin
                    state_next = (bus.wr_nack && can_retry) ? UPD_ISSUE : GAP;
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_next = (in_upd || tbl_index == LAST_IDX) ? DONE : FETCH;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = FETCH;
                end else if (bus.upd_valid) begin
                    state_next = UPD_ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_word_q  <= 24'd0;
            tbl_index  <= 5'd0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            gap_cnt    <= 16'd0;
            in_upd     <= 1'b0;
        end else begin
            state <= state_next;
            // busy and wr_valid are registered from the next state so they line up with it
            busy       <= is_busy(state_next);
            wr_valid_q <= is_issue(state_next);

            case (state)
                FETCH: begin
                    wr_word_q <= tbl_data;
                    in_upd    <= 1'b0;
                end
                WAIT, UPD_WAIT: begin
                    if (nack_seen && !can_retry) cfg_err <= 1'b1;
                end
                GAP: begin
                    if (gap_end) begin
                        gap_cnt <= 16'd0;
                        if (!in_upd) begin
                            if (tbl_index == LAST_IDX) cfg_done <= 1'b1;
                            else                       tbl_index <= tbl_index + 5'd1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (start) begin
                        cfg_done  <= 1'b0;
                        cfg_err   <= 1'b0;
                        tbl_index <= 5'd0;
                    end else if (bus.upd_valid) begin
                        wr_word_q <= {bus.upd_addr, bus.upd_data};
                        in_upd    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.upd_ready = upd_accept;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_word   = wr_word_q;
    assign bus.wr_dev    = DEV_ADDR;

endmodule

// File: doc/d5m_cfg_sequencer.md
# d5m_cfg_sequencer

Configuration sequencer for the D5M camera's I2C register-write path. It walks an external boot-register table and hands each 24-bit {register, data} word to the I2C write engine over a valid/ready handshake, waits for completion, and retries NACKed writes. After boot, it arbitrates runtime register updates (exposure, gains) onto the same engine. It sits between the sensor-control logic and the single I2C write engine that drives i2c_clk/i2c_data.

## Interface
- NUM_REGS, 25: boot-table entries, indices 0..NUM_REGS-1, max 32
- DEV_ADDR, 8'hBA: I2C device write address driven on wr_dev
- MAX_RETRY, 3: retries per word after a NACK (1..7)
- GAP_CYCLES, 16'd500: idle clk cycles after every completed write

- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; re-runs the boot table from index 0
- tbl_index  out  5  boot-table entry being read
- tbl_data  in  24  {reg[7:0], data[15:0]}; combinational from tbl_index
- upd_valid  in  1  runtime write request
- upd_addr  in  8  runtime register address
- upd_data  in  16  runtime register data
- upd_ready  out  1  runtime request accepted this cycle
- wr_valid  out  1  word offered to the I2C engine
- wr_dev  out  8  device address, constant DEV_ADDR
- wr_word  out  24  {reg, data} to the engine
- wr_ready  in  1  engine accepts the word
- wr_done  in  1  one-cycle pulse; transaction finished
- wr_nack  in  1  valid with wr_done; any of the four ACK slots missed
- busy  out  1  sequencer not in IDLE or DONE
- cfg_done  out  1  boot table finished, sticky until start or rst
- cfg_err  out  1  sticky; a word was abandoned after retries

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, GAP, DONE, UPD_ISSUE, UPD_WAIT.
- Reset: IDLE. On the first cycle after rst deasserts, go to FETCH with tbl_index=0. Boot runs without a start pulse.
- FETCH: latch tbl_data into wr_word. Clear the retry counter. Go to ISSUE.
- ISSUE: wr_valid=1 and wr_word held stable. When wr_valid&&wr_ready, drop wr_valid next cycle and go to WAIT.
- WAIT: ignore all inputs except wr_done.
  - wr_done&&!wr_nack: go to GAP.
  - wr_done&&wr_nack with retries<MAX_RETRY: increment the retry counter and return to ISSUE with the same word.
  - Retries exhausted: set cfg_err, then go to GAP. The word is skipped and the sequence continues.
- GAP: count GAP_CYCLES cycles.
  - If tbl_index==NUM_REGS-1, go to DONE and set cfg_done.
  - Otherwise increment tbl_index and go to FETCH.
- DONE: cfg_done=1.
  - start has priority: clear cfg_done and cfg_err, set tbl_index=0, go to FETCH.
  - Else if upd_valid: pulse upd_ready for one cycle, load wr_word={upd_addr,upd_data}, go to UPD_ISSUE.
- UPD_ISSUE and UPD_WAIT behave as ISSUE and WAIT, with the same retry and cfg_err rules. They then pass through GAP and return to DONE; tbl_index is unchanged.
- upd_ready is 0 in every state except DONE. Runtime requests are held off until boot completes.
- start is ignored in all states other than IDLE and DONE.
- wr_done outside WAIT or UPD_WAIT is ignored.

## Timing
- Reset values: wr_valid=0, wr_word=0, tbl_index=0, upd_ready=0, busy=0, cfg_done=0, cfg_err=0. wr_dev=DEV_ADDR always.
- Reset mid-transaction aborts at the next edge. rst is shared with the engine, so no in-flight word is resumed.
- tbl_data is sampled one cycle after tbl_index changes.
- wr_valid rises on the cycle after FETCH.
- Cycles per entry: 1 (FETCH) + handshake wait + engine time + GAP_CYCLES.
- Retry: wr_valid reasserts on the cycle after the NACKed wr_done.
- busy=1 from FETCH through GAP. busy is registered, so it aligns with the state.
- The retry counter is 3 bits. The GAP counter is 16 bits and saturation-free, because GAP_CYCLES is at least 1.

## Configuration
- D5M_CFG_RETRY_EN defined: NACK retries as described above.
- D5M_CFG_RETRY_EN undefined: MAX_RETRY is ignored. Any NACK immediately sets cfg_err and the word is skipped. The retry counter is not synthesized.

## Test plan
- Reset release, engine always ready, wr_done 20 cycles after accept, no NACK -> exactly 25 words in table order. The first word is 24'h000000. cfg_done=1 after the last GAP; cfg_err=0.
- Entry 3 NACKed twice then ACKed, MAX_RETRY=3 -> entry 3 issued 3 times with the same wr_word, then entry 4. cfg_err=0.
- Entry 5 NACKed 4 times -> 4 issues, then cfg_err=1 and entry 6 follows. cfg_done still sets at the end.
- upd_valid with upd_addr=8'h09, upd_data=16'h0400 held during boot -> upd_ready=0 until DONE. Then a single upd_ready pulse and wr_word=24'h090400.
- start and upd_valid asserted together in DONE -> the table restarts at index 0, upd_ready stays 0, and cfg_done/cfg_err clear.
- rst asserted during WAIT of entry 10 -> all outputs return to reset values next cycle. Boot then restarts from index 0.
